// File: rtl/game_sequencer.sv
// Round controller for the cannon game: target display, aim, launch, flight wait and result.
// Optional macro SEQ_SHOW_SKIP_EN: a shoot_req edge in SHOW_X/SHOW_Y skips the remaining dwell.
module game_sequencer #(
  parameter int SHOW_CYCLES    = 16,
  parameter int SHOTS_PER_GAME = 5,
  parameter int WIN_SCORE      = 3,
  parameter int FLIGHT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_new_game,
  input  logic       shoot_req,
  input  logic       aim_view,
  input  logic       result_valid,
  input  logic       hit,
  output logic [4:0] select,
  output logic       shoot_out,
  output logic       busy,
  output logic [3:0] score,
  output logic [2:0] shots_left,
  output logic       game_over,
  output logic       timeout_flag
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHOW_X = 3'd1,
    ST_SHOW_Y = 3'd2,
    ST_AIM    = 3'd3,
    ST_FLIGHT = 3'd4,
    ST_RESULT = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

  localparam int DW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SHOW_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1'b1);
  localparam logic [7:0]    TMO_LAST   = 8'(FLIGHT_TIMEOUT - 1);
  localparam logic [2:0]    SHOTS_INIT = 3'(SHOTS_PER_GAME);
  localparam logic [3:0]    WIN_THR    = 4'(WIN_SCORE);

  localparam logic [4:0] SEL_CANNON = 5'b10000;
  localparam logic [4:0] SEL_AIM    = 5'b01000;
  localparam logic [4:0] SEL_TX     = 5'b00100;
  localparam logic [4:0] SEL_TY     = 5'b00010;
  localparam logic [4:0] SEL_TRAJ   = 5'b00001;

  state_t        state_r, state_nxt_s;
  logic          start_d_r, shoot_d_r;
  logic          start_edge_s, shoot_edge_s, skip_s;
  logic          dwell_done_s, tmo_done_s;
  logic [DW-1:0] dwell_r, dwell_nxt_s;
  logic [7:0]    tmo_r, tmo_nxt_s;
  logic [3:0]    score_nxt_s;
  logic [2:0]    shots_nxt_s;
  logic [4:0]    select_nxt_s;
  logic          shoot_out_nxt_s, busy_nxt_s, game_over_nxt_s, timeout_flag_nxt_s;

  assign start_edge_s = start_new_game & ~start_d_r;
  assign shoot_edge_s = shoot_req & ~shoot_d_r;
  assign dwell_done_s = (dwell_r == DWELL_LAST);
  assign tmo_done_s   = (tmo_r == TMO_LAST);

`ifdef SEQ_SHOW_SKIP_EN
  assign skip_s = shoot_edge_s;
`else
  assign skip_s = 1'b0;
`endif

  // State register and edge-detect history; history loads live levels even in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      start_d_r <= start_new_game;
      shoot_d_r <= shoot_req;
    end else begin
      state_r   <= state_nxt_s;
      start_d_r <= start_new_game;
      shoot_d_r <= shoot_req;
    end
  end

  // Next-state logic; a start edge overrides every state
  always_comb begin
    state_nxt_s = state_r;
    if (start_edge_s) begin
      state_nxt_s = ST_SHOW_X;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = ST_IDLE;
        ST_SHOW_X: begin
          if (dwell_done_s || skip_s) state_nxt_s = ST_SHOW_Y;
          else                        state_nxt_s = ST_SHOW_X;
        end
        ST_SHOW_Y: begin
          if (dwell_done_s || skip_s) state_nxt_s = ST_AIM;
          else                        state_nxt_s = ST_SHOW_Y;
        end
        ST_AIM: begin
          if (shoot_edge_s) state_nxt_s = ST_FLIGHT;
          else              state_nxt_s = ST_AIM;
        end
        ST_FLIGHT: begin
          if (result_valid || tmo_done_s) state_nxt_s = ST_RESULT;
          else                            state_nxt_s = ST_FLIGHT;
        end
        ST_RESULT: begin
          if (!dwell_done_s)                                 state_nxt_s = ST_RESULT;
          else if ((score >= WIN_THR) || (shots_left == 3'd0)) state_nxt_s = ST_OVER;
          else                                               state_nxt_s = ST_SHOW_X;
        end
        ST_OVER:   state_nxt_s = ST_OVER;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Score, shot count and the dwell/timeout counters
  always_comb begin
    score_nxt_s = score;
    shots_nxt_s = shots_left;
    if (start_edge_s) begin
      score_nxt_s = 4'd0;
      shots_nxt_s = SHOTS_INIT;
    end else if ((state_r == ST_AIM) && shoot_edge_s) begin
      shots_nxt_s = shots_left - 3'd1;
    end else if ((state_r == ST_FLIGHT) && result_valid && hit && (score != 4'd15)) begin
      score_nxt_s = score + 4'd1;
    end else begin
      score_nxt_s = score;
      shots_nxt_s = shots_left;
    end

    if (!start_edge_s && (state_nxt_s == state_r) &&
        ((state_r == ST_SHOW_X) || (state_r == ST_SHOW_Y) || (state_r == ST_RESULT))) begin
      dwell_nxt_s = dwell_r + DWELL_ONE;
    end else begin
      dwell_nxt_s = {DW{1'b0}};
    end

    if (!start_edge_s && (state_r == ST_FLIGHT) && (state_nxt_s == ST_FLIGHT)) begin
      tmo_nxt_s = tmo_r + 8'd1;
    end else begin
      tmo_nxt_s = 8'd0;
    end
  end

  // Output decode from the next state so every output is registered
  always_comb begin
    select_nxt_s       = SEL_CANNON;
    busy_nxt_s         = 1'b1;
    game_over_nxt_s    = 1'b0;
    timeout_flag_nxt_s = 1'b0;
    shoot_out_nxt_s    = (state_r == ST_AIM) && (state_nxt_s == ST_FLIGHT);
    case (state_nxt_s)
      ST_IDLE:   busy_nxt_s = 1'b0;
      ST_SHOW_X: select_nxt_s = SEL_TX;
      ST_SHOW_Y: select_nxt_s = SEL_TY;
      ST_AIM:    select_nxt_s = aim_view ? SEL_AIM : SEL_CANNON;
      ST_FLIGHT: select_nxt_s = SEL_TRAJ;
      ST_RESULT: begin
        select_nxt_s = SEL_TRAJ;
        // Entering from FLIGHT without result_valid can only mean the timeout fired
        if (state_r == ST_FLIGHT) timeout_flag_nxt_s = ~result_valid;
        else                      timeout_flag_nxt_s = timeout_flag;
      end
      ST_OVER: begin
        busy_nxt_s      = 1'b0;
        game_over_nxt_s = 1'b1;
      end
      default:   busy_nxt_s = 1'b0;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      select       <= SEL_CANNON;
      shoot_out    <= 1'b0;
      busy         <= 1'b0;
      score        <= 4'd0;
      shots_left   <= SHOTS_INIT;
      game_over    <= 1'b0;
      timeout_flag <= 1'b0;
      dwell_r      <= {DW{1'b0}};
      tmo_r        <= 8'd0;
    end else begin
      select       <= select_nxt_s;
      shoot_out    <= shoot_out_nxt_s;
      busy         <= busy_nxt_s;
      score        <= score_nxt_s;
      shots_left   <= shots_nxt_s;
      game_over    <= game_over_nxt_s;
      timeout_flag <= timeout_flag_nxt_s;
      dwell_r      <= dwell_nxt_s;
      tmo_r        <= tmo_nxt_s;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer with SHOW_CYCLES=4, SHOTS=5, WIN=3, FLIGHT_TIMEOUT=8.
module tb_game_sequencer;

  localparam logic [4:0] SEL_CAN = 5'b10000;
  localparam logic [4:0] SEL_AIM = 5'b01000;
  localparam logic [4:0] SEL_SX  = 5'b00100;
  localparam logic [4:0] SEL_SY  = 5'b00010;
  localparam logic [4:0] SEL_TRJ = 5'b00001;

  logic       clk;
  logic       reset;
  logic       start_new_game;
  logic       shoot_req;
  logic       aim_view;
  logic       result_valid;
  logic       hit;
  logic [4:0] select;
  logic       shoot_out;
  logic       busy;
  logic [3:0] score;
  logic [2:0] shots_left;
  logic       game_over;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  cur_score;
  logic [2:0]  cur_shots;
  logic [15:0] obs;

  assign obs = {select, shoot_out, busy, score, shots_left, game_over, timeout_flag};

  game_sequencer #(
    .SHOW_CYCLES(4),
    .SHOTS_PER_GAME(5),
    .WIN_SCORE(3),
    .FLIGHT_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_new_game(start_new_game),
    .shoot_req(shoot_req),
    .aim_view(aim_view),
    .result_valid(result_valid),
    .hit(hit),
    .select(select),
    .shoot_out(shoot_out),
    .busy(busy),
    .score(score),
    .shots_left(shots_left),
    .game_over(game_over),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [4:0] sel, input logic so, input logic bsy,
                                     input logic [3:0] sc, input logic [2:0] sh,
                                     input logic go, input logic tf);
    return {sel, so, bsy, sc, sh, go, tf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      reset = (i < 2);
      start_new_game = (i < 5);
      shoot_req = 1'b1;
      exp_q.push_back(mk(SEL_CAN, 1'b0, 1'b0, 4'd0, 3'd5, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset[%0d]: actual=%b required=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_show_phases(input string nm);
    logic [15:0] e;
    cur_score = 4'd0;
    cur_shots = 3'd5;
    start_new_game = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(mk((i < 4) ? SEL_SX : ((i < 8) ? SEL_SY : SEL_CAN),
                         1'b0, 1'b1, 4'd0, 3'd5, 1'b0, 1'b0));
      tick();
      start_new_game = 1'b0;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s[%0d]: actual=%b required=%b", nm, i, obs, e);
      end
    end
  endtask

  task automatic test_aim_level();
    logic [15:0] e;
    aim_view = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        aim_view = 1'b0;
        shoot_req = 1'b0;
      end
      exp_q.push_back(mk((i < 3) ? SEL_AIM : SEL_CAN, 1'b0, 1'b1, 4'd0, 3'd5, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL aim_level[%0d]: actual=%b required=%b", i, obs, e);
      end
    end
  endtask

  // Starts in AIM with shoot_req low; rv_at = FLIGHT cycle carrying result_valid, 0 = none
  task automatic play_round(input string nm, input int rv_at, input logic h);
    logic [15:0] e;
    logic tf;
    int last;
    last = (rv_at == 0) ? 8 : rv_at;
    tf = (rv_at == 0);
    shoot_req = 1'b1;
    cur_shots = cur_shots - 3'd1;
    exp_q.push_back(mk(SEL_TRJ, 1'b1, 1'b1, cur_score, cur_shots, 1'b0, 1'b0));
    tick();
    shoot_req = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL %s_launch: actual=%b required=%b", nm, obs, e);
    end
    for (int k = 1; k <= last; k++) begin
      result_valid = (k == rv_at);
      hit = h;
      if (k == last) begin
        if ((rv_at != 0) && h) cur_score = cur_score + 4'd1;
        exp_q.push_back(mk(SEL_TRJ, 1'b0, 1'b1, cur_score, cur_shots, 1'b0, tf));
      end else begin
        exp_q.push_back(mk(SEL_TRJ, 1'b0, 1'b1, cur_score, cur_shots, 1'b0, 1'b0));
      end
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s_flight[%0d]: actual=%b required=%b", nm, k, obs, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      shoot_req = (i == 0);
      result_valid = (i == 0);
      hit = (i == 0);
      exp_q.push_back(mk(SEL_TRJ, 1'b0, 1'b1, cur_score, cur_shots, 1'b0, tf));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s_result[%0d]: actual=%b required=%b", nm, i, obs, e);
      end
    end
    shoot_req = 1'b0;
    result_valid = 1'b0;
    hit = 1'b0;
    if ((cur_score >= 4'd3) || (cur_shots == 3'd0)) begin
      exp_q.push_back(mk(SEL_CAN, 1'b0, 1'b0, cur_score, cur_shots, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s_over: actual=%b required=%b", nm, obs, e);
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp_q.push_back(mk((i < 4) ? SEL_SX : ((i < 8) ? SEL_SY : SEL_CAN),
                           1'b0, 1'b1, cur_score, cur_shots, 1'b0, 1'b0));
        tick();
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL %s_next[%0d]: actual=%b required=%b", nm, i, obs, e);
        end
      end
    end
  endtask

  task automatic test_over_hold();
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      shoot_req = (i % 2 == 1);
      result_valid = (i % 2 == 1);
      hit = 1'b1;
      exp_q.push_back(mk(SEL_CAN, 1'b0, 1'b0, cur_score, cur_shots, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL over_hold[%0d]: actual=%b required=%b", i, obs, e);
      end
    end
    shoot_req = 1'b0;
    result_valid = 1'b0;
    hit = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] e;
    for (int i = 0; i < 11; i++) begin
      shoot_req      = (i == 0);
      start_new_game = (i == 2);
      result_valid   = (i == 3);
      hit            = (i == 3);
      if (i == 0)      exp_q.push_back(mk(SEL_TRJ, 1'b1, 1'b1, cur_score, cur_shots - 3'd1, 1'b0, 1'b0));
      else if (i == 1) exp_q.push_back(mk(SEL_TRJ, 1'b0, 1'b1, cur_score, cur_shots - 3'd1, 1'b0, 1'b0));
      else             exp_q.push_back(mk((i < 6) ? SEL_SX : ((i < 10) ? SEL_SY : SEL_CAN),
                                          1'b0, 1'b1, 4'd0, 3'd5, 1'b0, 1'b0));
      tick();
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL abort[%0d]: actual=%b required=%b", i, obs, e);
      end
    end
    shoot_req = 1'b0;
    start_new_game = 1'b0;
    result_valid = 1'b0;
    hit = 1'b0;
    cur_score = 4'd0;
    cur_shots = 3'd5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start_new_game = 1'b1;
    shoot_req = 1'b1;
    aim_view = 1'b0;
    result_valid = 1'b0;
    hit = 1'b0;
    cur_score = 4'd0;
    cur_shots = 3'd5;
    test_reset();
    test_show_phases("show");
    test_aim_level();
    play_round("hit1", 3, 1'b1);
    play_round("hit2", 1, 1'b1);
    play_round("hit3", 5, 1'b1);
    test_over_hold();
    test_show_phases("restart");
    play_round("timeout", 0, 1'b1);
    play_round("rv_last", 8, 1'b1);
    test_abort();
    for (int r = 0; r < 5; r++) play_round("miss", 2, 1'b0);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level round controller for the cannon game. It sequences each game: display target X, display target Y, then an aim phase, shot launch, flight wait and result display. It gates the player's shoot request into a single-cycle launch pulse for the trajectory calculator. It drives the one-hot display select for the 5-bit output mux, and keeps score and remaining shots.

Parameters:
SHOW_CYCLES, 16, dwell cycles for the SHOW_X, SHOW_Y and RESULT states (>=1)
SHOTS_PER_GAME, 5, shots loaded at game start (1..7)
WIN_SCORE, 3, hits needed to end the game early (1..15)
FLIGHT_TIMEOUT, 255, maximum cycles waited for result_valid in FLIGHT (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_new_game  in  1  level input; acts on its rising edge (internal edge detect)
shoot_req  in  1  level input from controls; acts on its rising edge
aim_view  in  1  1 = show aim position instead of cannon position during AIM
result_valid  in  1  one-cycle pulse from trajectory calculator
hit  in  1  sampled only when result_valid=1
select  out  5  one-hot display select: 10000 cannon, 01000 aim, 00100 target_x, 00010 target_y, 00001 trajectory x
shoot_out  out  1  single-cycle launch pulse to trajectory calculator
busy  out  1  high in every state except IDLE and OVER
score  out  4  hits this game, saturates at 15
shots_left  out  3  remaining shots
game_over  out  1  high in OVER
timeout_flag  out  1  high in RESULT when the last shot timed out

Behaviour:
- Reset (clk edge with reset=1): state IDLE, select=10000, shoot_out=0, busy=0, score=0, shots_left=SHOTS_PER_GAME, game_over=0, timeout_flag=0, dwell/timeout counters=0. Edge-detect registers load the current input levels, so an input that is held high through reset does not fire.
- Priority: reset > start edge > state transitions.
- A start edge in any state goes to SHOW_X. It clears score and timeout_flag, loads shots_left and clears the counters. A start edge mid-game aborts the game; an in-flight result is discarded.
- IDLE: select=10000. Waits for a start edge.
- SHOW_X: select=00100. After exactly SHOW_CYCLES cycles in the state, goes to SHOW_Y.
- SHOW_Y: select=00010. After SHOW_CYCLES cycles, goes to AIM.
- AIM: select = aim_view ? 01000 : 10000.
  - A shoot_req rising edge moves to FLIGHT, raises shoot_out for exactly one cycle (the first FLIGHT cycle) and decrements shots_left.
- FLIGHT: select=00001. The timeout counter increments each cycle.
  - result_valid=1: if hit=1, score+1 (saturating), else unchanged; timeout_flag=0; go to RESULT.
  - Timeout counter reaches FLIGHT_TIMEOUT with no result_valid: counts as a miss, timeout_flag=1, go to RESULT.
  - result_valid in the same cycle as the timeout: result_valid wins.
- RESULT: select=00001 for SHOW_CYCLES cycles. Then:
  - score>=WIN_SCORE or shots_left==0: go to OVER.
  - Otherwise go to SHOW_X (the target generator has already advanced on result_valid).
- OVER: game_over=1, select=10000, score and shots_left held. Waits for a start edge.
- shoot_req edges outside AIM are ignored and are not queued. result_valid/hit outside FLIGHT are ignored.
- All outputs are registered and update on the clk edge after the triggering input edge. Latency: shoot_req rising at edge N is detected at N, and shoot_out is high during cycle N+1 only.
- The dwell counter is cleared on every state entry. The timeout counter is cleared on FLIGHT entry.

Optional Feature:
SEQ_SHOW_SKIP_EN:
- Defined: a shoot_req rising edge in SHOW_X or SHOW_Y skips the remaining dwell. SHOW_X jumps to SHOW_Y; SHOW_Y jumps to AIM. The edge does not fire a shot, and no shoot_out is produced.
- Undefined: shoot_req is ignored in SHOW_X and SHOW_Y; the dwell always runs the full SHOW_CYCLES.

Test Plan:
1. SHOW_CYCLES=4, reset, then start edge -> select 00100 for 4 cycles, then 00010 for 4 cycles, then 10000; busy=1; shots_left=5.
2. In AIM, shoot_req rises, then result_valid=1 with hit=1 three cycles later -> shoot_out high exactly 1 cycle; shots_left=4; score=1; select 00001 for 4 cycles; then back to SHOW_X.
3. Three hits with WIN_SCORE=3 -> after the third RESULT dwell: game_over=1, busy=0, select=10000, score=3, shots_left=2.
4. FLIGHT_TIMEOUT=8, no result_valid -> RESULT entered after 8 cycles; timeout_flag=1; score unchanged. Separately, result_valid on the 8th cycle -> timeout_flag=0.
5. Start edge during FLIGHT, then result_valid with hit=1 -> state SHOW_X, score=0, shots_left=5, and the late result is ignored.
6. shoot_req held high across reset and during SHOW_X (macro undefined) -> no shoot_out; in AIM the level already high does not fire, and a fresh 0→1 edge fires once.
